// File: rtl/serial_fas_if.sv
// serial_fas_if: handshake and operand/result bundle for serial_fas.
//   master: drives start, a_ns, a, b, cin; observes ready, valid, s, cout, ovf
//   slave : the arithmetic unit side
interface serial_fas_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             a_ns;
  logic             cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             valid;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;

  modport master (
    output start, a_ns, cin, a, b,
    input  ready, valid, s, cout, ovf
  );

  modport slave (
    input  start, a_ns, cin, a, b,
    output ready, valid, s, cout, ovf
  );
endinterface

// File: rtl/serial_fas.sv
// serial_fas: digit-serial adder/subtractor, DIGIT bits per clock, LSB first.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : serial_fas_if.slave
//           start/a_ns/a/b/cin in (sampled when accepted), ready/valid out,
//           s/cout/ovf registered results, updated only on completion.
//
// state  | meaning
// S_IDLE | waiting for start, ready=1
// S_RUN  | processing one digit per clock, counter 0..STEPS-1
// S_DONE | result held, valid=1, ready=1
module serial_fas #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input logic        clk,
  input logic        rst_n,
  serial_fas_if.slave bus
);
  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
    $error("serial_fas: WIDTH must be >= 2 and divisible by DIGIT");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic             r_mode;
  logic [WIDTH-1:0] r_s;
  logic             r_cout;
  logic             r_ovf;

  logic             w_accept;
  logic             w_last;
  logic [DIGIT:0]   w_slice;
  logic             w_c_msb;
  logic [WIDTH-1:0] w_res_nxt;

  assign w_accept = bus.start && (r_state != S_RUN);
  assign w_last   = (r_state == S_RUN) && (r_cnt == CW'(STEPS - 1));

  assign w_slice = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]}
                 + {{DIGIT{1'b0}}, r_carry};
  // Carry into the slice MSB recovered from the MSB sum bit; on the last
  // step this is the carry into bit WIDTH-1 of the whole operation.
  assign w_c_msb = r_a[DIGIT-1] ^ r_b[DIGIT-1] ^ w_slice[DIGIT-1];

  // Partial result holds the already-computed upper part; the new digit is
  // placed on top so that after STEPS shifts the LSB digit sits at bit 0.
  if (STEPS == 1) begin : g_single
    assign w_res_nxt = w_slice[DIGIT-1:0];
  end else begin : g_multi
    logic [WIDTH-DIGIT-1:0] r_part;
    assign w_res_nxt = {w_slice[DIGIT-1:0], r_part};
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_part <= '0;
      end else if (r_state == S_RUN) begin
        r_part <= w_res_nxt[WIDTH-1:DIGIT];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_nxt = S_RUN;
      S_RUN:   if (w_last)    w_state_nxt = S_DONE;
      S_DONE:  if (bus.start) w_state_nxt = S_RUN;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_mode  <= 1'b0;
      r_s     <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      // Subtract is a + ~b + ~cin; the borrow-in becomes an inverted carry.
      r_a     <= bus.a;
      r_b     <= bus.a_ns ? bus.b : ~bus.b;
      r_carry <= bus.a_ns ? bus.cin : ~bus.cin;
      r_mode  <= bus.a_ns;
      r_cnt   <= '0;
    end else if (r_state == S_RUN) begin
      r_a     <= r_a >> DIGIT;
      r_b     <= r_b >> DIGIT;
      r_carry <= w_slice[DIGIT];
      r_cnt   <= r_cnt + 1'b1;
      if (w_last) begin
        r_s    <= w_res_nxt;
        r_cout <= r_mode ? w_slice[DIGIT] : ~w_slice[DIGIT];
        r_ovf  <= w_c_msb ^ w_slice[DIGIT];
      end
    end
  end

  assign bus.ready = (r_state != S_RUN);
  assign bus.valid = (r_state == S_DONE);
  assign bus.s     = r_s;
  assign bus.cout  = r_cout;
  assign bus.ovf   = r_ovf;
endmodule

// File: tb/tb_serial_fas.sv
// tb_serial_fas: four serial_fas instances (WIDTH=8, DIGIT=1,2,4,8) sharing
// one stimulus set; start is steered to the selected instance only.
module tb_serial_fas;
  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       t_start = 1'b0;
  logic       t_a_ns = 1'b0;
  logic       t_cin = 1'b0;
  logic [7:0] t_a = '0;
  logic [7:0] t_b = '0;
  int         t_sel = 0;

  logic [3:0] w_ready, w_valid, w_cout, w_ovf;
  logic [7:0] w_s [4];

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    serial_fas_if #(.WIDTH(W)) u_if ();
    assign u_if.start = t_start && (t_sel == g);
    assign u_if.a_ns  = t_a_ns;
    assign u_if.cin   = t_cin;
    assign u_if.a     = t_a;
    assign u_if.b     = t_b;
    assign w_ready[g] = u_if.ready;
    assign w_valid[g] = u_if.valid;
    assign w_cout[g]  = u_if.cout;
    assign w_ovf[g]   = u_if.ovf;
    assign w_s[g]     = u_if.s;
    serial_fas #(.WIDTH(W), .DIGIT(1 << g)) u_dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (u_if)
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  task automatic model(input logic mode, input logic [7:0] a, input logic [7:0] b,
                       input logic cin, output logic [7:0] s, output logic co,
                       output logic ov);
    int u, r, sa, sb, ci;
    sa = $signed(a);
    sb = $signed(b);
    ci = cin ? 1 : 0;
    if (mode) begin
      u  = int'(a) + int'(b) + ci;
      co = (u > 255);
      r  = sa + sb + ci;
    end else begin
      u  = int'(a) - int'(b) - ci;
      co = (int'(a) < int'(b) + ci);
      r  = sa - sb - ci;
    end
    s  = u[7:0];
    ov = (r > 127) || (r < -128);
  endtask

  task automatic run_op(input int sel, input logic mode, input logic [7:0] a,
                        input logic [7:0] b, input logic cin, input bit toggle,
                        input bit hold, input string tag);
    logic [7:0] es;
    logic       ec, eo;
    int         cyc;
    bit         rdy_bad;
    model(mode, a, b, cin, es, ec, eo);
    t_sel = sel; t_a_ns = mode; t_a = a; t_b = b; t_cin = cin; t_start = 1'b1;
    @(posedge clk); #1;
    t_start = hold;
    cyc = 0;
    rdy_bad = 0;
    while (!w_valid[sel] && cyc < 40) begin
      if (w_ready[sel]) rdy_bad = 1;
      if (toggle) begin
        t_start = 1'($urandom);
        t_a_ns  = 1'($urandom);
        t_cin   = 1'($urandom);
        t_a     = 8'($urandom);
        t_b     = 8'($urandom);
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (!hold) t_start = 1'b0;
    check({tag, "_lat"},   32'(cyc), 32'(8 >> sel));
    check({tag, "_rdy0"},  32'(rdy_bad), 32'(0));
    check({tag, "_rdy1"},  32'(w_ready[sel]), 32'(1));
    check({tag, "_s"},     32'(w_s[sel]), 32'(es));
    check({tag, "_cout"},  32'(w_cout[sel]), 32'(ec));
    check({tag, "_ovf"},   32'(w_ovf[sel]), 32'(eo));
  endtask

  task automatic check_cleared(input string tag);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_rdy%0d", tag, i),  32'(w_ready[i]), 32'(1));
      check($sformatf("%s_vld%0d", tag, i),  32'(w_valid[i]), 32'(0));
      check($sformatf("%s_s%0d", tag, i),    32'(w_s[i]), 32'(0));
      check($sformatf("%s_cout%0d", tag, i), 32'(w_cout[i]), 32'(0));
      check($sformatf("%s_ovf%0d", tag, i),  32'(w_ovf[i]), 32'(0));
    end
  endtask

  initial begin
    bit saw_valid;

    // Reset with random inputs applied
    t_sel = int'($urandom_range(3, 0));
    t_start = 1'($urandom); t_a_ns = 1'($urandom); t_cin = 1'($urandom);
    t_a = 8'($urandom); t_b = 8'($urandom);
    repeat (3) @(posedge clk);
    #1;
    check_cleared("rst");
    rst_n = 1'b1;
    t_start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_cleared("idle");

    // Directed, DIGIT=1
    run_op(0, 1'b1, 8'h7F, 8'h01, 1'b0, 0, 0, "add_7f_01");
    run_op(0, 1'b1, 8'hFF, 8'h00, 1'b1, 0, 0, "add_ff_00_c");
    run_op(0, 1'b0, 8'h05, 8'h07, 1'b0, 0, 0, "sub_05_07");
    run_op(0, 1'b0, 8'h80, 8'h01, 1'b0, 0, 0, "sub_80_01");
    run_op(0, 1'b0, 8'h10, 8'h0F, 1'b1, 0, 0, "sub_10_0f_b");
    // Wider digits
    run_op(2, 1'b1, 8'hA5, 8'h5B, 1'b0, 0, 0, "add_a5_5b_d4");
    run_op(3, 1'b1, 8'hA5, 8'h5B, 1'b0, 0, 0, "add_a5_5b_d8");
    run_op(1, 1'b0, 8'h00, 8'hFF, 1'b1, 0, 0, "sub_00_ff_d2");

    // Inputs churning during RUN
    run_op(0, 1'b1, 8'h3C, 8'h4D, 1'b1, 1, 0, "tgl_d1");
    run_op(2, 1'b0, 8'h12, 8'h34, 1'b0, 1, 0, "tgl_d4");

    // Back-to-back with start held high through DONE
    run_op(0, 1'b1, 8'h11, 8'h22, 1'b0, 0, 1, "b2b_a");
    run_op(0, 1'b0, 8'h40, 8'hC0, 1'b1, 0, 0, "b2b_b");
    run_op(1, 1'b1, 8'h99, 8'h99, 1'b1, 0, 1, "b2b_c");
    run_op(1, 1'b1, 8'h01, 8'hFE, 1'b0, 0, 0, "b2b_d");

    // Reset in the middle of an operation (counter at 3)
    run_op(0, 1'b1, 8'h7F, 8'h01, 1'b0, 0, 0, "pre_rst");
    t_sel = 0; t_a_ns = 1'b1; t_a = 8'hFF; t_b = 8'hFF; t_cin = 1'b1; t_start = 1'b1;
    @(posedge clk); #1;
    t_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_cleared("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    saw_valid = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (w_valid[0]) saw_valid = 1;
    end
    check("midrst_novalid", 32'(saw_valid), 32'(0));
    check("midrst_s_hold", 32'(w_s[0]), 32'(0));
    run_op(0, 1'b1, 8'h7F, 8'h01, 1'b0, 0, 0, "post_rst");

    // Randomized operations per digit size
    for (int sel = 0; sel < 4; sel++) begin
      for (int n = 0; n < 1000; n++) begin
        run_op(sel, 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom),
               ($urandom_range(3, 0) == 0), ($urandom_range(7, 0) == 0),
               $sformatf("rnd_d%0d", 1 << sel));
      end
      t_start = 1'b0;
      @(posedge clk); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
